// File: rtl/sequential_restoring_divider_pkg.sv
// Shared arithmetic-unit constants plus divider FSM state type and counter width.
package Pkg_Global;
  localparam int DW    = 16;
  localparam int CNT_W = $clog2(DW);

  localparam logic [DW-1:0] ZERO     = '0;
  localparam logic [DW-1:0] ONE      = {{(DW-1){1'b0}}, 1'b1};
  localparam logic          BIT_ZERO = 1'b0;
  localparam logic          BIT_ONE  = 1'b1;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;
endpackage

// File: rtl/sequential_restoring_divider_if.sv
// Start/done handshake and operand/result bundle for the sequential divider.
interface sequential_restoring_divider_if;
  import Pkg_Global::*;

  logic          start;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/sequential_restoring_divider_div_sign_adjust.sv
// Conditional two's-complement negate: magnitude at capture, sign restore at FIX.
module div_sign_adjust #(
  parameter int W = 16
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? -val : val;
endmodule

// File: rtl/sequential_restoring_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module sequential_restoring_divider
  import Pkg_Global::*;
(
  input  logic                           clk,
  input  logic                           rst,
  sequential_restoring_divider_if.slave  bus
);

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    r;
  logic [DW-1:0]    q;
  logic [DW-1:0]    d;
  logic [DW:0]      r_sh;
  logic [DW:0]      diff;
  logic             sub_ok;
  logic             accept;

  logic [DW-1:0]    dvd_mag, dsr_mag, q_fix, r_fix, dz_rem;
  logic [DW-1:0]    quotient_q, remainder_q;
  logic             dz_q;

  assign accept = bus.start && (state == IDLE || state == DONE);

  // Restored R is always below D, so its top bit is zero and is not stored.
  assign r_sh   = {r, q[DW-1]};
  assign diff   = r_sh - {BIT_ZERO, d};
  assign sub_ok = ~diff[DW];

`ifdef SIGNED_DIV_EN
  logic          neg_q, neg_r;
  logic [DW-1:0] dvd_raw;

  div_sign_adjust #(.W(DW)) u_abs_dvd (.val(bus.dividend), .neg(bus.dividend[DW-1]), .res(dvd_mag));
  div_sign_adjust #(.W(DW)) u_abs_dsr (.val(bus.divisor),  .neg(bus.divisor[DW-1]),  .res(dsr_mag));
  div_sign_adjust #(.W(DW)) u_neg_q   (.val(q),            .neg(neg_q),              .res(q_fix));
  div_sign_adjust #(.W(DW)) u_neg_r   (.val(r),            .neg(neg_r),              .res(r_fix));

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q   <= BIT_ZERO;
      neg_r   <= BIT_ZERO;
      dvd_raw <= ZERO;
    end else if (accept) begin
      neg_q   <= bus.dividend[DW-1] ^ bus.divisor[DW-1];
      neg_r   <= bus.dividend[DW-1];
      dvd_raw <= bus.dividend;
    end
  end

  assign dz_rem = dvd_raw;
`else
  assign dvd_mag = bus.dividend;
  assign dsr_mag = bus.divisor;
  assign q_fix   = q;
  assign r_fix   = r;
  // With D=0 every step subtracts nothing, so R ends up holding the dividend.
  assign dz_rem  = r;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.busy    = BIT_ZERO;
    bus.done    = BIT_ZERO;
    case (state)
      IDLE: if (bus.start) state_nx = ITER;
      ITER: begin
        bus.busy = BIT_ONE;
        if (cnt == CNT_W'(DW-1)) state_nx = FIX;
      end
      FIX: begin
        bus.busy = BIT_ONE;
        state_nx = DONE;
      end
      DONE: begin
        bus.done = BIT_ONE;
        state_nx = bus.start ? ITER : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= ZERO;
      q           <= ZERO;
      d           <= ZERO;
      cnt         <= '0;
      quotient_q  <= ZERO;
      remainder_q <= ZERO;
      dz_q        <= BIT_ZERO;
    end else if (state == ITER) begin
      r   <= sub_ok ? diff[DW-1:0] : r_sh[DW-1:0];
      q   <= {q[DW-2:0], sub_ok};
      cnt <= cnt + CNT_W'(1);
    end else if (state == FIX) begin
      if (d == ZERO) begin
        quotient_q  <= '1;
        remainder_q <= dz_rem;
        dz_q        <= BIT_ONE;
      end else begin
        quotient_q  <= q_fix;
        remainder_q <= r_fix;
        dz_q        <= BIT_ZERO;
      end
    end else if (accept) begin
      r   <= ZERO;
      q   <= dvd_mag;
      d   <= dsr_mag;
      cnt <= '0;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_sequential_restoring_divider.sv
// Scoreboard bench for the sequential divider: model results queued at start, checked on done.
module tb_sequential_restoring_divider;
  import Pkg_Global::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sequential_restoring_divider_if bus();
  sequential_restoring_divider dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    int            sc;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [DW-1:0] a, b;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [DW-1:0] x, logic [DW-1:0] y);
    exp_t e;
    e.sc = 0;
    e.dz = 1'b0;
    if (y == '0) begin
      e.q  = '1;
      e.r  = x;
      e.dz = 1'b1;
    end
`ifdef SIGNED_DIV_EN
    else if (x == {1'b1, {(DW-1){1'b0}}} && y == '1) begin
      e.q = x;
      e.r = '0;
    end else begin
      e.q = $signed(x) / $signed(y);
      e.r = $signed(x) % $signed(y);
    end
`else
    else begin
      e.q = x / y;
      e.r = x % y;
    end
`endif
    return e;
  endfunction

  // Called at a negedge; the start is sampled at the next rising edge.
  task automatic go(logic [DW-1:0] x, logic [DW-1:0] y);
    exp_t e;
    bus.start    = 1'b1;
    bus.dividend = x;
    bus.divisor  = y;
    if (!bus.busy) begin
      e    = model(x, y);
      e.sc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // A downstream flop captures done at edge start+DW+2.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("quotient",    bus.quotient,    e.q);
        chk("remainder",   bus.remainder,   e.r);
        chk("div_by_zero", bus.div_by_zero, e.dz);
        chk("latency",     cyc + 1 - e.sc,  DW + 2);
        chk("busy_in_done", bus.busy, 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient",  bus.quotient,    0);
    chk("rst_remainder", bus.remainder,   0);
    chk("rst_dz",        bus.div_by_zero, 0);
    chk("rst_busy",      bus.busy,        0);
    chk("rst_done",      bus.done,        0);
    rst = 1'b0;
    @(negedge clk);

    go(16'd100, 16'd7);
    drain();
    chk("q_100_7", bus.quotient, 14);
    chk("r_100_7", bus.remainder, 2);
    chk("dz_100_7", bus.div_by_zero, 0);

    go(16'd5, 16'd0);
    drain();
    chk("q_5_0", bus.quotient, 16'hFFFF);
    chk("r_5_0", bus.remainder, 16'h0005);
    chk("dz_5_0", bus.div_by_zero, 1);

`ifdef SIGNED_DIV_EN
    go(16'hFF9C, 16'h0007);
    drain();
    chk("q_m100_7", bus.quotient, 16'hFFF2);
    chk("r_m100_7", bus.remainder, 16'hFFFE);
    go(16'h8000, 16'hFFFF);
    drain();
    chk("q_min_m1", bus.quotient, 16'h8000);
    chk("r_min_m1", bus.remainder, 16'h0000);
    chk("dz_min_m1", bus.div_by_zero, 0);
`endif

    // Second start lands at cycle 5 while busy and must be ignored.
    go(16'hFFFF, 16'h0010);
    repeat (4) @(negedge clk);
    go(16'h0004, 16'h0002);
    drain();
`ifndef SIGNED_DIV_EN
    chk("q_ignored", bus.quotient, 16'h0FFF);
    chk("r_ignored", bus.remainder, 16'h000F);
`endif

    // Reset at cycle 8 of 1000/3 aborts with no done pulse.
    go(16'd1000, 16'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("abort_quotient",  bus.quotient,    0);
    chk("abort_remainder", bus.remainder,   0);
    chk("abort_dz",        bus.div_by_zero, 0);
    chk("abort_busy",      bus.busy,        0);
    chk("abort_done",      bus.done,        0);
    rst = 1'b0;
    repeat (DW + 6) @(negedge clk);
    go(16'd9, 16'd3);
    drain();
    chk("q_9_3", bus.quotient, 3);
    chk("r_9_3", bus.remainder, 0);

    // New start in the DONE cycle of 50/5.
    go(16'd50, 16'd5);
    for (int i = 0; i < 100 && !bus.done; i++) @(negedge clk);
    if (!bus.done) chk("b2b_timeout", 0, 1);
    else go(16'd7, 16'd2);
    drain();
    chk("q_7_2", bus.quotient, 3);
    chk("r_7_2", bus.remainder, 1);

    repeat (24) begin
      a = DW'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = DW'($urandom_range(1, 15));
        2:       b = DW'($urandom_range(1, 400));
        default: b = DW'($urandom);
      endcase
      go(a, b);
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
